// File: rtl/wbc_vic_pkg.sv
// Shared types and constants for the wbc_vic vectored interrupt controller.
package wbc_vic_pkg;
   localparam int VEC_W = 16;
   localparam logic [VEC_W-1:0] SPUR_VEC_DEF = 16'o000;

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      ACK
   } state_t;
endpackage

// File: rtl/vic_arbiter.sv
// Combinational request search: first set request at or after start, wrapping modulo N.
module vic_arbiter #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] winner,
   output logic          valid
);
   logic [2*N-1:0] rot;
   logic [IW:0]    sum;

   always_comb begin
      rot    = {req, req} >> start;
      valid  = 1'b0;
      sum    = '0;
      // Walk downwards so the closest request to start is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum   = {1'b0, start} + (IW + 1)'(i);
            valid = 1'b1;
         end
      end
      if (sum >= (IW + 1)'(N))
         sum = sum - (IW + 1)'(N);
      winner = sum[IW-1:0];
   end
endmodule

// File: rtl/wbc_vic.sv
// Vectored interrupt controller: arbitrates irq_i, answers istb with ivec/iack, pulses ack_o.
// Rotating priority when VIC_ROUND_ROBIN_EN is defined, fixed priority (index 0 highest) otherwise.
module wbc_vic
   import wbc_vic_pkg::*;
#(
   parameter int              N        = 8,
   parameter logic [VEC_W-1:0] SPUR_VEC = SPUR_VEC_DEF
) (
   input  logic               clk_p,
   input  logic               rst,
   input  logic [N-1:0]       irq_i,
   input  logic [VEC_W*N-1:0] vec_i,
   output logic [N-1:0]       ack_o,
   output logic               virq,
   input  logic               istb,
   output logic               iack,
   output logic [VEC_W-1:0]   ivec
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t           state, state_nxt;
   logic [IW-1:0]    win_q, arb_win, start;
   logic             spur_q, arb_vld;
   logic [N-1:0]     serve_mask;
   logic [VEC_W-1:0] vec_arr [N];

`ifdef VIC_ROUND_ROBIN_EN
   logic [IW-1:0] last_q;
   always_comb start = (last_q == IW'(N - 1)) ? '0 : last_q + 1'b1;
`else
   assign start = '0;
`endif

   always_comb begin
      for (int i = 0; i < N; i++)
         vec_arr[i] = vec_i[VEC_W*i +: VEC_W];
   end

   vic_arbiter #(.N(N), .IW(IW)) u_arb (
      .req    (irq_i),
      .start  (start),
      .winner (arb_win),
      .valid  (arb_vld)
   );

   always_ff @(posedge clk_p) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (istb) state_nxt = LATCH;
         LATCH:   state_nxt = ACK;
         ACK:     if (!istb) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The source being served is hidden from virq so the CPU is not re-interrupted by it.
   always_comb begin
      serve_mask = '0;
      if (state != IDLE && !spur_q)
         serve_mask = N'(1) << win_q;
   end

   always_ff @(posedge clk_p) begin
      if (rst) begin
         virq   <= 1'b0;
         iack   <= 1'b0;
         ivec   <= '0;
         ack_o  <= '0;
         win_q  <= '0;
         spur_q <= 1'b0;
`ifdef VIC_ROUND_ROBIN_EN
         last_q <= IW'(N - 1);
`endif
      end else begin
         virq  <= |(irq_i & ~serve_mask);
         ack_o <= '0;
         case (state)
            LATCH: begin
               iack   <= 1'b1;
               ivec   <= arb_vld ? vec_arr[arb_win] : SPUR_VEC;
               win_q  <= arb_win;
               spur_q <= !arb_vld;
`ifdef VIC_ROUND_ROBIN_EN
               if (arb_vld)
                  last_q <= arb_win;
`endif
            end
            ACK: begin
               if (!istb) begin
                  iack <= 1'b0;
                  ivec <= '0;
                  if (!spur_q)
                     ack_o <= N'(1) << win_q;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
